// File: rtl/bin2bcd_iter.sv
// bin2bcd_iter: iterative binary-to-BCD converter (shift-and-add-3).
// One input bit is consumed per clock. A valid/ready handshake on both the
// input and the output allows the result to be held under backpressure. A
// new value can be accepted in the same cycle the previous result is taken.
module bin2bcd_iter #(
    parameter int unsigned BIN_W  = 8,
    parameter int unsigned DIGITS = 3,
    parameter int unsigned SIGNED = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      binary_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  sign_out
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned SR_W  = BCD_W + BIN_W;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);

    // 10^n at elaboration time; 64 bits covers every legal DIGITS value.
    function automatic logic [63:0] pow10(input int unsigned n);
        logic [63:0] acc;
        acc = 64'd1;
        for (int unsigned i = 0; i < n; i++) begin
            acc = acc * 64'd10;
        end
        return acc;
    endfunction

    localparam logic [63:0] DEC_RANGE = pow10(DIGITS);
    localparam logic [63:0] BIN_MAX   = (64'd1 << BIN_W) - 64'd1;

    // Reject configurations that cannot represent every input value.
    if (BIN_W < 32'd4 || BIN_W > 32'd32) begin : g_bad_bin_w
        $error("bin2bcd_iter: BIN_W must lie in 4..32");
    end
    if (DIGITS < 32'd1 || DIGITS > 32'd19) begin : g_bad_digits
        $error("bin2bcd_iter: DIGITS must lie in 1..19");
    end
    if (DEC_RANGE <= BIN_MAX) begin : g_too_few_digits
        $error("bin2bcd_iter: 10^DIGITS must exceed 2^BIN_W-1");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Correct one BCD nibble before the shift so it cannot exceed 9 afterwards.
    function automatic logic [3:0] digit_adjust(input logic [3:0] nib);
        logic [3:0] res;
        if (nib >= 4'd5) begin
            res = nib + 4'd3;
        end else begin
            res = nib;
        end
        return res;
    endfunction

    // One double-dabble iteration over the whole {digits, binary} register.
    function automatic logic [SR_W-1:0] shift_step(input logic [SR_W-1:0] sr);
        logic [SR_W-1:0] adj;
        adj = sr;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            adj[BIN_W + 4*i +: 4] = digit_adjust(sr[BIN_W + 4*i +: 4]);
        end
        return {adj[SR_W-2:0], 1'b0};
    endfunction

    // Sign of the incoming value; always positive for unsigned configurations.
    function automatic logic is_negative(input logic [BIN_W-1:0] v);
        logic neg;
        if (SIGNED != 32'd0) begin
            neg = v[BIN_W-1];
        end else begin
            neg = 1'b0;
        end
        return neg;
    endfunction

    // Magnitude of the incoming value. The negation is BIN_W bits wide, so
    // the most negative value maps onto 2^(BIN_W-1) as an unsigned number.
    function automatic logic [BIN_W-1:0] magnitude(input logic [BIN_W-1:0] v);
        logic [BIN_W-1:0] mag;
        if (is_negative(v)) begin
            mag = ~v + BIN_W'(1);
        end else begin
            mag = v;
        end
        return mag;
    endfunction

    state_t             state_q,     state_d;
    logic [SR_W-1:0]    sr_q,        sr_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic               sign_q,      sign_d;
    logic [BCD_W-1:0]   bcd_q,       bcd_d;
    logic               sign_out_q,  sign_out_d;
    logic               out_valid_q, out_valid_d;

    logic               accept_s;
    logic [SR_W-1:0]    sr_shift_s;

    // Input handshake: free when idle, or when the held result leaves this cycle.
    always_comb begin
        in_ready = 1'b0;
        case (state_q)
            IDLE:    in_ready = 1'b1;
            DONE:    in_ready = out_ready;
            default: in_ready = 1'b0;
        endcase
        accept_s = in_valid && in_ready;
    end

    // Next value of the conversion register for a SHIFT cycle.
    always_comb begin
        sr_shift_s = shift_step(sr_q);
    end

    // FSM next state, datapath loads and result capture.
    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        cnt_d       = cnt_q;
        sign_d      = sign_q;
        bcd_d       = bcd_q;
        sign_out_d  = sign_out_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                out_valid_d = 1'b0;
                if (accept_s) begin
                    sr_d    = {{BCD_W{1'b0}}, magnitude(binary_in)};
                    cnt_d   = CNT_W'(BIN_W);
                    sign_d  = is_negative(binary_in);
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end

            SHIFT: begin
                sr_d        = sr_shift_s;
                out_valid_d = 1'b0;
                if (cnt_q <= CNT_W'(1)) begin
                    // Last input bit has just entered the digit field.
                    cnt_d       = {CNT_W{1'b0}};
                    bcd_d       = sr_shift_s[SR_W-1 -: BCD_W];
                    sign_out_d  = sign_q;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    cnt_d   = cnt_q - CNT_W'(1);
                    state_d = SHIFT;
                end
            end

            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (accept_s) begin
                        sr_d    = {{BCD_W{1'b0}}, magnitude(binary_in)};
                        cnt_d   = CNT_W'(BIN_W);
                        sign_d  = is_negative(binary_in);
                        state_d = SHIFT;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end

            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight conversion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sr_q        <= {SR_W{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            sign_q      <= 1'b0;
            bcd_q       <= {BCD_W{1'b0}};
            sign_out_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
            sign_q      <= sign_d;
            bcd_q       <= bcd_d;
            sign_out_q  <= sign_out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign bcd_out   = bcd_q;
    assign sign_out  = sign_out_q;

endmodule

// File: tb/tb_bin2bcd_iter.sv
// Directed bench for bin2bcd_iter: three configurations (8-bit unsigned,
// 8-bit signed, 16-bit unsigned) sharing one clock and reset.
module tb_bin2bcd_iter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    // 8-bit unsigned instance
    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_sign;
    logic [7:0]  a_bin;
    logic [11:0] a_bcd;
    // 8-bit signed instance
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_sign;
    logic [7:0]  b_bin;
    logic [11:0] b_bcd;
    // 16-bit unsigned instance
    logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_sign;
    logic [15:0] c_bin;
    logic [19:0] c_bcd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bin2bcd_iter #(.BIN_W(8), .DIGITS(3), .SIGNED(0)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .binary_in(a_bin), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .bcd_out(a_bcd), .sign_out(a_sign));

    bin2bcd_iter #(.BIN_W(8), .DIGITS(3), .SIGNED(1)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .binary_in(b_bin), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .bcd_out(b_bcd), .sign_out(b_sign));

    bin2bcd_iter #(.BIN_W(16), .DIGITS(5), .SIGNED(0)) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .binary_in(c_bin), .out_valid(c_out_valid), .out_ready(c_out_ready),
        .bcd_out(c_bcd), .sign_out(c_sign));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Decimal reference for the 16-bit instance.
    function automatic logic [19:0] ref16(input int v);
        logic [19:0] r;
        int t;
        t = v;
        r = 20'd0;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic conv_a(input logic [7:0] v, input logic [11:0] exp, input string tag);
        int n;
        a_out_ready = 1'b1;
        a_bin = v;
        a_in_valid = 1'b1;
        chk({tag, "_in_ready"}, a_in_ready, 1);
        tick;
        a_in_valid = 1'b0;
        a_bin = ~v;
        n = 1;
        while (a_out_valid !== 1'b1 && n < 40) begin
            tick;
            n++;
        end
        chk({tag, "_latency"}, n, 9);
        chk({tag, "_bcd"}, a_bcd, exp);
        chk({tag, "_sign"}, a_sign, 0);
        tick;
        chk({tag, "_consumed"}, a_out_valid, 0);
        chk({tag, "_retained"}, a_bcd, exp);
        a_out_ready = 1'b0;
    endtask

    task automatic conv_b(input logic [7:0] v, input logic s, input logic [11:0] exp, input string tag);
        int n;
        b_out_ready = 1'b1;
        b_bin = v;
        b_in_valid = 1'b1;
        tick;
        b_in_valid = 1'b0;
        n = 1;
        while (b_out_valid !== 1'b1 && n < 40) begin
            tick;
            n++;
        end
        chk({tag, "_latency"}, n, 9);
        chk({tag, "_bcd"}, b_bcd, exp);
        chk({tag, "_sign"}, b_sign, s);
        tick;
        chk({tag, "_consumed"}, b_out_valid, 0);
        b_out_ready = 1'b0;
    endtask

    task automatic conv_c(input logic [15:0] v, input logic [19:0] exp, input string tag);
        int n;
        c_out_ready = 1'b1;
        c_bin = v;
        c_in_valid = 1'b1;
        tick;
        c_in_valid = 1'b0;
        n = 1;
        while (c_out_valid !== 1'b1 && n < 60) begin
            tick;
            n++;
        end
        chk({tag, "_latency"}, n, 17);
        chk({tag, "_bcd"}, c_bcd, exp);
        chk({tag, "_sign"}, c_sign, 0);
        tick;
        c_out_ready = 1'b0;
    endtask

    initial begin
        int n;
        a_in_valid = 1'b0; a_out_ready = 1'b0; a_bin = 8'h00;
        b_in_valid = 1'b0; b_out_ready = 1'b0; b_bin = 8'h00;
        c_in_valid = 1'b0; c_out_ready = 1'b0; c_bin = 16'h0000;

        // Reset state
        #2;
        chk("rst_a_out_valid", a_out_valid, 0);
        chk("rst_a_bcd", a_bcd, 0);
        chk("rst_a_sign", a_sign, 0);
        chk("rst_a_in_ready", a_in_ready, 1);
        chk("rst_b_sign", b_sign, 0);
        chk("rst_c_bcd", c_bcd, 0);
        tick;
        tick;
        rst_n = 1'b1;

        // Unsigned 8-bit vectors
        conv_a(8'hFF, 12'h255, "u8_ff");
        conv_a(8'h00, 12'h000, "u8_00");
        conv_a(8'd100, 12'h100, "u8_100");
        conv_a(8'd9, 12'h009, "u8_9");
        conv_a(8'd10, 12'h010, "u8_10");

        // Signed 8-bit vectors
        conv_b(8'h80, 1'b1, 12'h128, "s8_80");
        conv_b(8'hFF, 1'b1, 12'h001, "s8_ff");
        conv_b(8'h00, 1'b0, 12'h000, "s8_00");
        conv_b(8'hF6, 1'b1, 12'h010, "s8_f6");
        conv_b(8'h7F, 1'b0, 12'h127, "s8_7f");

        // 16-bit vectors and sampled sweep against the decimal reference
        conv_c(16'hFFFF, 20'h65535, "w16_ffff");
        conv_c(16'd0, 20'h00000, "w16_0");
        conv_c(16'd9999, 20'h09999, "w16_9999");
        conv_c(16'd10000, 20'h10000, "w16_10000");
        for (int v = 0; v <= 65535; v += 97) begin
            conv_c(v[15:0], ref16(v), "sweep");
        end

        // Backpressure: result held for 5 cycles with out_ready low
        a_out_ready = 1'b0;
        a_bin = 8'd99;
        a_in_valid = 1'b1;
        tick;
        a_in_valid = 1'b0;
        n = 1;
        while (a_out_valid !== 1'b1 && n < 40) begin
            tick;
            n++;
        end
        chk("bp_latency", n, 9);
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", a_out_valid, 1);
            chk("bp_bcd", a_bcd, 12'h099);
            chk("bp_in_ready", a_in_ready, 0);
            tick;
        end
        a_out_ready = 1'b1;
        #1;
        chk("bp_in_ready_on_take", a_in_ready, 1);
        tick;
        chk("bp_consumed", a_out_valid, 0);
        a_out_ready = 1'b0;

        // Back-to-back: take 200 and accept 42 on the same edge
        a_bin = 8'd200;
        a_in_valid = 1'b1;
        tick;
        a_in_valid = 1'b0;
        n = 1;
        while (a_out_valid !== 1'b1 && n < 40) begin
            tick;
            n++;
        end
        chk("b2b_first_bcd", a_bcd, 12'h200);
        a_out_ready = 1'b1;
        a_in_valid = 1'b1;
        a_bin = 8'd42;
        tick;
        a_in_valid = 1'b0;
        a_out_ready = 1'b0;
        chk("b2b_valid_low", a_out_valid, 0);
        chk("b2b_no_idle", a_in_ready, 0);
        chk("b2b_retained", a_bcd, 12'h200);
        n = 1;
        while (a_out_valid !== 1'b1 && n < 40) begin
            tick;
            n++;
        end
        chk("b2b_latency", n, 9);
        chk("b2b_bcd", a_bcd, 12'h042);
        a_out_ready = 1'b1;
        tick;
        a_out_ready = 1'b0;

        // Reset during the 4th SHIFT cycle
        a_bin = 8'd255;
        a_in_valid = 1'b1;
        tick;
        a_in_valid = 1'b0;
        tick;
        tick;
        tick;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", a_out_valid, 0);
        chk("mid_rst_bcd", a_bcd, 0);
        chk("mid_rst_sign", a_sign, 0);
        chk("mid_rst_in_ready", a_in_ready, 1);
        chk("mid_rst_b_bcd", b_bcd, 0);
        tick;
        tick;
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            chk("post_rst_no_result", a_out_valid, 0);
            tick;
        end
        conv_a(8'd7, 12'h007, "post_rst_7");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
